// File: rtl/inst_issuer.sv
// inst_issuer: buffers a program and feeds it word by word onto the processor data bus.
// Optional ISSUER_LOOP_EN repeats the program forever instead of finishing in DONE.
module inst_issuer #(
  parameter int DEPTH = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       wr_en,
  input  logic [9:0] load_word,
  output logic       full,
  input  logic       start,
  input  logic [1:0] T,
  input  logic       Clr,
  output logic [9:0] Data,
  output logic       busy,
  output logic       done,
  output logic [4:0] count
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    OPER,
    DONE
  } state_t;

  state_t          state, state_n;
  logic [9:0]      buffer [DEPTH];
  logic [AW-1:0]   wptr, rptr, rptr_n;
  logic [4:0]      count_n;
  logic            wr_ok;
  logic            cur_ld;
  logic            has_opnd;
  logic            head_ld;
`ifdef ISSUER_LOOP_EN
  logic [AW-1:0]   pstart;
  logic [4:0]      plen;
`endif

  assign full     = (count == 5'(DEPTH));
  assign busy     = (state == ISSUE) || (state == OPER);
  assign done     = (state == DONE);
  assign wr_ok    = (state == IDLE) && wr_en && !full;
  // in OPER count still includes the current word
  assign has_opnd = (count > 5'd1);
  assign head_ld  = (buffer[rptr][9:8] == 2'b00) &&
                    (buffer[rptr][3:0] == 4'b0000);

  // next-state, read pointer and occupancy
  always_comb begin
    state_n = state;
    rptr_n  = rptr;
    count_n = count + {4'b0, wr_ok};
    unique case (state)
      IDLE: begin
        if (start && count != 5'd0)
          state_n = ISSUE;
      end
      ISSUE: begin
        if (T == 2'b00) begin
          state_n = OPER;
          rptr_n  = rptr + AW'(1);
        end
      end
      OPER: begin
        if (Clr) begin
          if (cur_ld && has_opnd) begin
            rptr_n  = rptr + AW'(1);
            count_n = count - 5'd2;
          end else begin
            count_n = count - 5'd1;
          end
          if (count_n == 5'd0) begin
`ifdef ISSUER_LOOP_EN
            state_n = ISSUE;
            rptr_n  = pstart;
            count_n = plen;
`else
            state_n = DONE;
`endif
          end else begin
            state_n = ISSUE;
          end
        end
      end
      DONE: begin
        if (start)
          state_n = IDLE;
      end
    endcase
  end

  // bus word: head in ISSUE, ld operand during T=01
  always_comb begin
    Data = 10'b0;
    unique case (1'b1)
      state == ISSUE:
        Data = buffer[rptr];
      state == OPER:
        if (cur_ld && has_opnd && T == 2'b01)
          Data = buffer[rptr];
      default: Data = 10'b0;
    endcase
  end

  // control registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      wptr   <= '0;
      rptr   <= '0;
      count  <= '0;
      cur_ld <= 1'b0;
`ifdef ISSUER_LOOP_EN
      pstart <= '0;
      plen   <= '0;
`endif
    end else begin
      state <= state_n;
      rptr  <= rptr_n;
      count <= count_n;
      if (wr_ok)
        wptr <= wptr + AW'(1);
      if (state == ISSUE && T == 2'b00)
        cur_ld <= head_ld;
`ifdef ISSUER_LOOP_EN
      if (state == IDLE && state_n == ISSUE) begin
        pstart <= rptr;
        plen   <= count_n;
      end
`endif
    end
  end

  // program storage, contents are don't-care until written
  always_ff @(posedge clk) begin
    if (wr_ok)
      buffer[wptr] <= load_word;
  end

endmodule

// File: tb/tb_inst_issuer.sv
// tb_inst_issuer: directed scenarios plus random traffic against a queue model.
// The model holds the unconsumed program as a queue of words.
module tb_inst_issuer;

  localparam int DEPTH = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       wr_en = 1'b0;
  logic [9:0] load_word = '0;
  logic       full;
  logic       start = 1'b0;
  logic [1:0] T = 2'b00;
  logic       Clr = 1'b0;
  logic [9:0] Data;
  logic       busy;
  logic       done;
  logic [4:0] count;

  int tests = 0;
  int fails = 0;
  bit chk_en = 1'b0;

  inst_issuer #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en),
    .load_word(load_word), .full(full),
    .start(start), .T(T), .Clr(Clr),
    .Data(Data), .busy(busy), .done(done),
    .count(count)
  );

  always #5 clk = ~clk;

  // model: 0 idle, 1 issue, 2 oper, 3 done
  int         m_mode = 0;
  logic [9:0] q[$];
  logic [9:0] prog[$];
  logic [9:0] cur;

  function automatic bit isld(input logic [9:0] w);
    return w[9:8] == 2'b00 && w[3:0] == 4'b0000;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_mode = 0;
      q.delete();
      prog.delete();
    end else begin
      case (m_mode)
        0: begin
          bit go;
          go = start && q.size() > 0;
          if (wr_en && q.size() < DEPTH)
            q.push_back(load_word);
          if (go) begin
            prog = q;
            m_mode = 1;
          end
        end
        1: if (T == 2'b00) begin
          cur = q.pop_front();
          m_mode = 2;
        end
        2: if (Clr) begin
          if (isld(cur) && q.size() > 0)
            void'(q.pop_front());
          if (q.size() == 0) begin
`ifdef ISSUER_LOOP_EN
            q = prog;
            m_mode = 1;
`else
            m_mode = 3;
`endif
          end else begin
            m_mode = 1;
          end
        end
        default: if (start) m_mode = 0;
      endcase
    end
  end

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               name, act, exp, $time);
    end
  endtask

  // compare DUT against the model every cycle
  always @(negedge clk) begin
    #1;
    if (chk_en) begin
      int mc;
      logic [9:0] md;
      mc = q.size() + (m_mode == 2 ? 1 : 0);
      md = '0;
      if (m_mode == 1)
        md = q[0];
      else if (m_mode == 2 && isld(cur) &&
               T == 2'b01 && q.size() > 0)
        md = q[0];
      check("data", 32'(Data), 32'(md));
      check("count", 32'(count), 32'(mc));
      check("full", 32'(full), 32'(mc == DEPTH));
      check("busy", 32'(busy),
            32'(m_mode == 1 || m_mode == 2));
      check("done", 32'(done), 32'(m_mode == 3));
    end
  end

  task automatic cyc(input logic w, input logic [9:0] word,
                     input logic s, input logic [1:0] t,
                     input logic c);
    @(negedge clk);
    wr_en = w;
    load_word = word;
    start = s;
    T = t;
    Clr = c;
    #2;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    wr_en = 0; start = 0; Clr = 0; T = 2'b00;
    @(negedge clk);
    rst = 1'b0;
    chk_en = 1'b1;
  endtask

  localparam logic [9:0] ADD = 10'b0010010010;
  localparam logic [9:0] LD  = 10'b0001000000;
  localparam logic [9:0] OPN = 10'b0000101101;
  localparam logic [9:0] SUB = 10'b0100100001;

  initial begin
    do_reset();
    #2;
    check("rst_count", 32'(count), 0);
    check("rst_data", 32'(Data), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_full", 32'(full), 0);

    // single add instruction
    cyc(1, ADD, 0, 2'b01, 0);
    cyc(0, 0, 1, 2'b01, 0);
    cyc(0, 0, 0, 2'b00, 0);
    check("add_data", 32'(Data), 32'(ADD));
    check("add_busy", 32'(busy), 1);
    cyc(0, 0, 0, 2'b01, 0);
    cyc(0, 0, 0, 2'b11, 1);
    cyc(0, 0, 0, 2'b00, 0);
    check("add_done", 32'(done), 1);
    check("add_count", 32'(count), 0);
    check("add_data0", 32'(Data), 0);

    // ld with operand
    do_reset();
    cyc(1, LD, 0, 2'b11, 0);
    cyc(1, OPN, 0, 2'b11, 0);
    cyc(0, 0, 1, 2'b11, 0);
    cyc(0, 0, 0, 2'b00, 0);
    check("ld_instr", 32'(Data), 32'(LD));
    cyc(0, 0, 0, 2'b01, 0);
    check("ld_opnd", 32'(Data), 32'(OPN));
    check("ld_count", 32'(count), 2);
    cyc(0, 0, 0, 2'b10, 1);
    cyc(0, 0, 0, 2'b11, 0);
    check("ld_done", 32'(done), 1);
    check("ld_count0", 32'(count), 0);

    // ld as last word without operand
    do_reset();
    cyc(1, LD, 0, 2'b11, 0);
    cyc(0, 0, 1, 2'b11, 0);
    cyc(0, 0, 0, 2'b00, 0);
    cyc(0, 0, 0, 2'b01, 0);
    check("ldlast_data", 32'(Data), 0);
    cyc(0, 0, 0, 2'b10, 1);
    cyc(0, 0, 0, 2'b11, 0);
    check("ldlast_done", 32'(done), 1);

    // fill past capacity
    do_reset();
    for (int i = 0; i < 9; i++)
      cyc(1, 10'(i + 16), 0, 2'b00, 0);
    cyc(0, 0, 0, 2'b00, 0);
    check("full_flag", 32'(full), 1);
    check("full_count", 32'(count), 8);

    // reset in the middle of an ld
    do_reset();
    cyc(1, LD, 0, 2'b11, 0);
    cyc(1, OPN, 0, 2'b11, 0);
    cyc(0, 0, 1, 2'b11, 0);
    cyc(0, 0, 0, 2'b00, 0);
    cyc(0, 0, 0, 2'b01, 0);
    cyc(0, 0, 0, 2'b10, 0);
    check("mid_busy_pre", 32'(busy), 1);
    rst = 1'b1;
    #1;
    check("mid_data", 32'(Data), 0);
    check("mid_busy", 32'(busy), 0);
    check("mid_count", 32'(count), 0);
    @(negedge clk);
    rst = 1'b0;

    // start away from T=00 waits in ISSUE
    do_reset();
    cyc(1, SUB, 0, 2'b10, 0);
    cyc(0, 0, 1, 2'b10, 0);
    cyc(0, 0, 0, 2'b10, 0);
    check("wait_data0", 32'(Data), 32'(SUB));
    cyc(0, 0, 0, 2'b01, 0);
    cyc(0, 0, 0, 2'b11, 1);
    check("wait_data1", 32'(Data), 32'(SUB));
    check("wait_busy", 32'(busy), 1);
    cyc(0, 0, 0, 2'b00, 0);
    cyc(0, 0, 0, 2'b01, 0);
    check("wait_oper", 32'(count), 1);
    check("wait_data2", 32'(Data), 0);

`ifdef ISSUER_LOOP_EN
    // two-word program wraps back to its head
    do_reset();
    cyc(1, ADD, 0, 2'b11, 0);
    cyc(1, SUB, 0, 2'b11, 0);
    cyc(0, 0, 1, 2'b11, 0);
    cyc(0, 0, 0, 2'b00, 0);
    cyc(0, 0, 0, 2'b11, 1);
    cyc(0, 0, 0, 2'b00, 0);
    check("loop_w1", 32'(Data), 32'(SUB));
    cyc(0, 0, 0, 2'b11, 1);
    cyc(0, 0, 0, 2'b01, 0);
    check("loop_w0", 32'(Data), 32'(ADD));
    check("loop_done", 32'(done), 0);
    check("loop_count", 32'(count), 2);
`endif

    // random traffic
    do_reset();
    for (int n = 0; n < 4000; n++) begin
      logic [9:0] w;
      @(negedge clk);
      rst = ($urandom_range(199) == 0);
      w = 10'($urandom);
      if ($urandom_range(3) == 0)
        w = {2'b00, w[7:4], 4'b0000};
      wr_en = $urandom_range(1);
      load_word = w;
      start = ($urandom_range(9) == 0);
      T = 2'($urandom);
      Clr = ($urandom_range(3) == 0);
    end
    @(negedge clk);
    rst = 1'b0;
    #3;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/inst_issuer.md
INST_ISSUER -- requirements
Module: inst_issuer

Interface
REQ-001 SHALL have parameter DEPTH, default 8: program buffer depth in 10-bit words, a power of 2 between 2 and 16.
REQ-002 SHALL have port clk  input  1: the single clock, rising-edge active.
REQ-003 SHALL have port rst  input  1: reset, asynchronous and active-high.
REQ-004 SHALL have port wr_en  input  1: write load_word into the buffer tail.
REQ-005 SHALL have port load_word  input  10: program word (instruction or ld operand).
REQ-006 SHALL have port full  output  1: the buffer holds DEPTH words.
REQ-007 SHALL have port start  input  1: begin issuing from the buffer head.
REQ-008 SHALL have port T  input  2: current processor timestep.
REQ-009 SHALL have port Clr  input  1: end-of-instruction pulse from the processor controller.
REQ-010 SHALL have port Data  output  10: word driven onto the processor external data input.
REQ-011 SHALL have port busy  output  1: high in the ISSUE or OPER states.
REQ-012 SHALL have port done  output  1: high in the DONE state.
REQ-013 SHALL have port count  output  5: number of words currently stored.

Function
REQ-014 SHALL implement states IDLE, ISSUE, OPER and DONE, with IDLE as the reset state.
REQ-015 SHALL accept a write only in IDLE with full=0: load_word goes to buffer[wptr], wptr increments modulo DEPTH, count increments.
REQ-016 SHALL ignore a write when full=1 or when not in IDLE; the buffer, wptr and count are unchanged.
REQ-017 SHALL move IDLE->ISSUE on start=1 with count>0; start with count=0 stays in IDLE.
REQ-018 SHALL ignore start outside IDLE.
REQ-019 SHALL, in ISSUE, drive Data=buffer[rptr] continuously; Data is 10'b0 in IDLE and DONE.
REQ-020 SHALL leave ISSUE on the first rising edge where T=2'b00.
  - rptr latches the word as the current instruction and advances by 1.
  - State becomes OPER.
REQ-021 SHALL treat the current instruction as ld when bits[9:8]=00 and bits[3:0]=0000.
  - In OPER, Data is driven with buffer[rptr], the operand word, while T=2'b01.
REQ-022 SHALL leave OPER on a rising edge with Clr=1.
  - For ld, rptr advances by one more to skip the operand.
  - Every consumed word decrements count (1 or 2 per instruction).
  - If count reaches 0 the state becomes DONE; otherwise it becomes ISSUE.
REQ-023 SHALL go straight to DONE when an ld is the final word and has no operand.
  - Data=10'b0 in T=01; count decrements by 1.
REQ-024 SHALL ignore Clr outside OPER.
REQ-025 SHALL, when start=1 and Clr=1 arrive in the same cycle, act on Clr only when in OPER and on start only when in IDLE; the two never conflict.
REQ-026 SHALL wrap rptr and wptr modulo DEPTH, and full SHALL equal (count==DEPTH).
REQ-027 SHALL move DONE->IDLE on start=1 without re-issuing; wptr and rptr keep their values.
REQ-028 SHALL update Data combinationally from state, rptr and T, with zero-cycle latency to bus visibility.

Reset
REQ-029 SHALL, on rst=1 at any time including mid-instruction, immediately set state=IDLE, wptr=0, rptr=0, count=0, Data=0, busy=0, done=0 and full=0.
REQ-030 SHALL leave buffer contents unspecified after reset, and they SHALL never be observed before being rewritten.

Configuration
REQ-031 SHALL, when ISSUER_LOOP_EN is defined, enter ISSUE instead of DONE when count would reach 0.
  - rptr returns to the first word of the program and count is restored to the program length.
  - The program repeats until rst=1.
REQ-032 SHALL, when ISSUER_LOOP_EN is undefined, behave per REQ-022 and have no loop logic.

Verification
REQ-033 SHALL cover single instruction: write 0010010010 (add R0,R1), start, T=00 -> Data=0010010010; Clr at T=11 -> DONE, count=0.
REQ-034 SHALL cover ld operand: write 0001000000 then 0000101101, start -> Data=0001000000 at T=00 and Data=0000101101 at T=01; Clr -> DONE.
REQ-035 SHALL cover full: write 9 words with DEPTH=8 -> full=1 after 8 words, 9th ignored, count=8.
REQ-036 SHALL cover reset mid-operation: assert rst in OPER at T=10 -> Data=0, state IDLE, count=0 with no clock edge.
REQ-037 SHALL cover wait for T: start while T=10 -> stays ISSUE, Data held, until a T=00 edge.
REQ-038 SHALL cover loop with ISSUER_LOOP_EN defined: 2-word program, 2 Clr pulses -> Data returns to word 0, done stays 0.
